// File: rtl/dev_bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge.
// Latency: n/a (declarations only); backpressure: n/a.
package dev_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam int unsigned SLOT_BYTES  = 16;
  localparam int unsigned SLOT_SHIFT  = 4;
  localparam logic [3:0]  BYTEEN_WORD = 4'b1111;

  // Request fields captured when a CPU access is accepted.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

endpackage

// File: rtl/dev_bridge_decode.sv
// Maps a CPU byte address onto a slot hit flag and slot index.
// Latency: combinational; backpressure: none.
module dev_bridge_decode
  import dev_bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV = 2,
  parameter logic [31:0] BASE    = 32'h0000_7F00,
  localparam int unsigned IDX_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [31:0] offset;

  // Offset form avoids overflow of BASE + window size near the top of memory.
  assign offset = addr_i - BASE;
  assign hit_o  = (addr_i >= BASE) && (offset < 32'(SLOT_BYTES * NUM_DEV));
  assign idx_o  = offset[SLOT_SHIFT +: IDX_W];

endmodule

// File: rtl/dev_bridge.sv
// Bridges CPU data-port accesses to NUM_DEV peripheral slots with wait states and timeout.
// Latency: 2..TIMEOUT+1 cycles to cpu_ready_o (1 on decode error); CPU stalls until the ready pulse.
module dev_bridge
  import dev_bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV = 2,
  parameter logic [31:0] BASE    = 32'h0000_7F00,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [31:0]           cpu_wd_i,
  input  logic [3:0]            cpu_byteen_i,
  output logic                  cpu_ready_o,
  output logic [31:0]           cpu_rd_o,
  output logic                  cpu_err_o,
  output logic [NUM_DEV-1:0]    dev_sel_o,
  output logic                  dev_we_o,
  output logic [31:0]           dev_addr_o,
  output logic [31:0]           dev_wd_o,
  input  logic [NUM_DEV-1:0]    dev_ack_i,
  input  logic [32*NUM_DEV-1:0] dev_rd_i,
  input  logic [NUM_DEV-1:0]    dev_irq_i,
  output logic [NUM_DEV-1:0]    irq_out_o
);

  localparam int unsigned IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  req_t               req_q, req_d;
  logic [NUM_DEV-1:0] sel_q, sel_d;
  logic               dev_we_q, dev_we_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [31:0]        rd_q, rd_d;
  logic [NUM_DEV-1:0] irq_q, irq_d;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [31:0]        slot_rd [NUM_DEV];

  dev_bridge_decode #(
    .NUM_DEV (NUM_DEV),
    .BASE    (BASE)
  ) u_decode (
    .addr_i (cpu_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  for (genvar g = 0; g < NUM_DEV; g++) begin : g_slot_rd
    assign slot_rd[g] = dev_rd_i[32*g +: 32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    req_d    = req_q;
    sel_d    = sel_q;
    dev_we_d = dev_we_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    rd_d     = rd_q;
    irq_d    = dev_irq_i;

    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        rd_d  = '0;
        if (cpu_req_i) begin
          req_d = '{we: cpu_we_i, addr: cpu_addr_i, wd: cpu_wd_i};
          idx_d = dec_idx;
          // Device registers are word-only; erroring accesses never touch a slot.
          if (!dec_hit || (cpu_we_i && (cpu_byteen_i != BYTEEN_WORD))) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            cnt_d    = '0;
            sel_d    = NUM_DEV'(1) << dec_idx;
            dev_we_d = cpu_we_i;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (dev_ack_i[idx_q]) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          err_d    = 1'b0;
          rd_d     = req_q.we ? '0 : slot_rd[idx_q];
          sel_d    = '0;
          dev_we_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          rd_d     = '0;
          sel_d    = '0;
          dev_we_d = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        rd_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      req_q    <= '0;
      sel_q    <= '0;
      dev_we_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= '0;
      irq_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      dev_we_q <= dev_we_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      irq_q    <= irq_d;
    end
  end

  assign cpu_ready_o = ready_q;
  assign cpu_rd_o    = rd_q;
  assign cpu_err_o   = err_q;
  assign dev_sel_o   = sel_q;
  assign dev_we_o    = dev_we_q;
  assign dev_addr_o  = req_q.addr;
  assign dev_wd_o    = req_q.wd;
  assign irq_out_o   = irq_q;

endmodule

// File: tb/tb_dev_bridge.sv
// Self-checking bench for dev_bridge: directed cases then randomized accesses vs. a transaction model.
// Latency: n/a; backpressure: the bench plays the CPU holding cpu_req until ready.
module tb_dev_bridge;

  localparam int          N    = 2;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int          TO   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            cpu_req, cpu_we;
  logic [31:0]     cpu_addr, cpu_wd;
  logic [3:0]      cpu_byteen;
  logic            cpu_ready, cpu_err;
  logic [31:0]     cpu_rd;
  logic [N-1:0]    dev_sel;
  logic            dev_we;
  logic [31:0]     dev_addr, dev_wd;
  logic [N-1:0]    dev_ack;
  logic [32*N-1:0] dev_rd;
  logic [N-1:0]    dev_irq, irq_out;
  logic [31:0]     slot_dat [N];

  int vectors     = 0;
  int miscompares = 0;

  for (genvar g = 0; g < N; g++) begin : g_rd
    assign dev_rd[32*g +: 32] = slot_dat[g];
  end

  dev_bridge #(.NUM_DEV(N), .BASE(BASE), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wd_i     (cpu_wd),
    .cpu_byteen_i (cpu_byteen),
    .cpu_ready_o  (cpu_ready),
    .cpu_rd_o     (cpu_rd),
    .cpu_err_o    (cpu_err),
    .dev_sel_o    (dev_sel),
    .dev_we_o     (dev_we),
    .dev_addr_o   (dev_addr),
    .dev_wd_o     (dev_wd),
    .dev_ack_i    (dev_ack),
    .dev_rd_i     (dev_rd),
    .dev_irq_i    (dev_irq),
    .irq_out_o    (irq_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; irq_out must reflect the irq level present at the edge (zero under reset).
  task automatic step();
    logic [N-1:0] exp_irq;
    exp_irq = reset ? '0 : dev_irq;
    @(posedge clk);
    #1;
    chk("irq_out", 32'(irq_out), 32'(exp_irq));
    dev_irq = N'($urandom);
  endtask

  // One CPU transaction; ack_cyc is the cycle the target slot acks (0 = never).
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int ack_cyc);
    logic        hit, derr, eerr;
    int          idx, lat;
    logic [31:0] erd;
    logic [N-1:0] oh;
    hit  = (addr >= BASE) && (addr < BASE + 16 * N);
    idx  = hit ? int'((addr - BASE) / 16) : 0;
    oh   = N'(1) << idx;
    derr = !hit || (we && be != 4'hF);
    if (derr) begin
      lat = 1; eerr = 1'b1;
    end else if (ack_cyc >= 1 && ack_cyc <= TO) begin
      lat = ack_cyc + 1; eerr = 1'b0;
    end else begin
      lat = TO + 1; eerr = 1'b1;
    end
    erd = (eerr || we) ? 32'h0 : slot_dat[idx];

    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wd = wd; cpu_byteen = be;
    dev_ack = '0;
    for (int c = 1; c <= lat; c++) begin
      step();
      chk({tag, ".ready"}, 32'(cpu_ready), 32'(c == lat));
      chk({tag, ".sel"}, 32'(dev_sel), (!derr && c < lat) ? 32'(oh) : 32'h0);
      chk({tag, ".dev_we"}, 32'(dev_we), 32'(!derr && c < lat && we));
      chk({tag, ".dev_addr"}, dev_addr, addr);
      chk({tag, ".dev_wd"}, dev_wd, wd);
      if (c == lat) begin
        chk({tag, ".err"}, 32'(cpu_err), 32'(eerr));
        chk({tag, ".rd"}, cpu_rd, erd);
        cpu_req = 1'b0;
        dev_ack = '0;
      end else begin
        // Request inputs wander while held; only the latched copy may matter.
        cpu_addr = $urandom; cpu_wd = $urandom; cpu_we = 1'($urandom); cpu_byteen = 4'($urandom);
        dev_ack = (N'($urandom) & ~oh) | ((c == ack_cyc) ? oh : '0);
      end
    end
    step();
    chk({tag, ".ready_pulse"}, 32'(cpu_ready), 32'h0);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
    cpu_byteen = '0; dev_ack = '0; dev_irq = '0;
    for (int i = 0; i < N; i++) slot_dat[i] = '0;
    step(); step();
    chk("rst.ready", 32'(cpu_ready), 32'h0);
    chk("rst.err", 32'(cpu_err), 32'h0);
    chk("rst.rd", cpu_rd, 32'h0);
    chk("rst.sel", 32'(dev_sel), 32'h0);
    chk("rst.dev_we", 32'(dev_we), 32'h0);
    chk("rst.dev_addr", dev_addr, 32'h0);
    chk("rst.dev_wd", dev_wd, 32'h0);
    reset = 1'b0;
    step();

    slot_dat[1] = 32'h0000_00AB;
    access("rd_slot1", 1'b0, 32'h0000_7F14, 32'h0, 4'h0, 1);
    access("wr_slot0", 1'b1, 32'h0000_7F04, 32'h7, 4'hF, 3);
    access("rd_unmapped", 1'b0, 32'h0000_7F24, 32'h0, 4'hF, 1);
    access("wr_partial", 1'b1, 32'h0000_7F00, 32'h5, 4'b0011, 1);
    access("rd_below", 1'b0, 32'h0000_7EFC, 32'h0, 4'hF, 1);
    access("timeout", 1'b0, 32'h0000_7F00, 32'h0, 4'hF, 0);
    slot_dat[0] = 32'hCAFE_0001;
    access("ack_at_timeout", 1'b0, 32'h0000_7F08, 32'h0, 4'hF, TO);
    access("rd_last_word", 1'b0, 32'h0000_7F1F, 32'h0, 4'h0, 2);

    dev_irq = 2'b01;
    step();
    chk("irq_dir", 32'(irq_out), 32'h1);

    // Reset while a slot is selected: select drops, no ready pulse.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F10; cpu_byteen = 4'hF; dev_ack = '0;
    step();
    chk("mid.sel", 32'(dev_sel), 32'h2);
    step();
    reset = 1'b1;
    step();
    chk("mid.sel_drop", 32'(dev_sel), 32'h0);
    chk("mid.ready", 32'(cpu_ready), 32'h0);
    chk("mid.dev_addr", dev_addr, 32'h0);
    cpu_req = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < TO + 2; i++) begin
      step();
      chk("mid.no_ready", 32'(cpu_ready), 32'h0);
    end
    access("post_reset", 1'b0, 32'h0000_7F10, 32'h0, 4'hF, 2);

    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic        w;
      logic [3:0]  be;
      for (int i = 0; i < N; i++) slot_dat[i] = $urandom;
      a  = BASE - 32 + 32'($urandom_range(0, 16 * N + 63));
      w  = 1'($urandom);
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      access("rand", w, a, $urandom, be, int'($urandom_range(0, TO + 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
